// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parameter legality limits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_MIN_DATA_BITS = 5;
    localparam int UART_MAX_DATA_BITS = 9;
    localparam int UART_MIN_CLK_DIV   = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each bit period.
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (clear || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine with valid/ready input and back-to-back frames.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 busy
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < UART_MIN_DATA_BITS || DATA_BITS > UART_MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS out of range");
    end
    if (CLK_DIV < UART_MIN_CLK_DIV || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_frame: CLK_DIV out of range");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 tick;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Divider is held cleared while idle so every frame starts on a fresh bit period.
    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    assign in_ready = (state_q == IDLE) ||
                      ((state_q == STOP) && tick && (bit_cnt_q == STOP_LAST));
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: ;
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_d      = parity_q;
`else
                        state_d   = STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // An accept overrides the stop-bit exit so the next start bit follows with no gap.
        if (accept) begin
            state_d   = START;
            shift_d   = in_data;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d  = (^in_data) ^ (PARITY_ODD != 0);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: per-cycle scoreboard of tx/busy/in_ready across several configurations.
module tb_uart_tx_frame;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef struct packed {
        logic tx;
        logic busy;
        logic ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid [4];
    logic [7:0] in_data  [4];
    logic       tx_w     [4];
    logic       ready_w  [4];
    logic       busy_w   [4];

    int   sel = 0;
    logic obs_tx, obs_busy, obs_ready;
    exp_t sb [$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    always_comb begin
        obs_tx    = tx_w[sel];
        obs_busy  = busy_w[sel];
        obs_ready = ready_w[sel];
    end

    // Instances: 0 = 8N1, 1 = 8N2, 2 = 5N1, 3 = 8N1 with odd parity selected.
    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ready_w[0]),
        .in_data(in_data[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ready_w[1]),
        .in_data(in_data[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ready_w[2]),
        .in_data(in_data[2][4:0]), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(ready_w[3]),
        .in_data(in_data[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    function automatic int frameLen(input int db, input int stops);
        return DIV * (1 + db + PAR_BITS + stops);
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected line activity for one frame, one entry per clk cycle.
    task automatic pushFrame(input logic [7:0] data, input int db, input int stops, input logic podd);
        int   nb;
        logic bitv;
        logic par;
        exp_t e;
        nb  = 1 + db + PAR_BITS + stops;
        par = podd;
        for (int j = 0; j < db; j++) par = par ^ data[j];
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                             bitv = 1'b0;
            else if (b <= db)                       bitv = data[b-1];
            else if (PAR_BITS == 1 && b == db + 1)  bitv = par;
            else                                    bitv = 1'b1;
            for (int c = 0; c < DIV; c++) begin
                e.tx    = bitv;
                e.busy  = 1'b1;
                e.ready = (b == nb - 1) && (c == DIV - 1);
                sb.push_back(e);
            end
        end
    endtask

    // Called at a falling edge; the accept happens at the following rising edge.
    task automatic applyStimulus(input int s, input logic [7:0] data, input int db,
                                 input int stops, input logic podd, input bit keep_valid);
        sel         = s;
        in_data[s]  = data;
        in_valid[s] = 1'b1;
        pushFrame(data, db, stops, podd);
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid[s] = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                checkBit($sformatf("%s scoreboard_empty c%0d", tag, i), 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                checkBit($sformatf("%s tx c%0d", tag, i), obs_tx, e.tx);
                checkBit($sformatf("%s busy c%0d", tag, i), obs_busy, e.busy);
                checkBit($sformatf("%s in_ready c%0d", tag, i), obs_ready, e.ready);
            end
        end
    endtask

    task automatic checkIdle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkBit($sformatf("%s idle_tx c%0d", tag, i), obs_tx, 1'b1);
            checkBit($sformatf("%s idle_busy c%0d", tag, i), obs_busy, 1'b0);
            checkBit($sformatf("%s idle_ready c%0d", tag, i), obs_ready, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkBit($sformatf("reset tx u%0d", i), tx_w[i], 1'b1);
            checkBit($sformatf("reset ready u%0d", i), ready_w[i], 1'b1);
            checkBit($sformatf("reset busy u%0d", i), busy_w[i], 1'b0);
        end
        rst = 1'b0;

        $display("[TB] single frame 0xA5, 8N1");
        sel = 0;
        checkIdle("pre_a5", 2);
        applyStimulus(0, 8'hA5, 8, 1, 1'b0, 1'b0);
        checkOutput("a5", frameLen(8, 1));
        checkIdle("post_a5", 4);

        $display("[TB] back-to-back 0x00 then 0xFF with in_valid held");
        applyStimulus(0, 8'h00, 8, 1, 1'b0, 1'b1);
        in_data[0] = 8'hFF;
        pushFrame(8'hFF, 8, 1, 1'b0);
        checkOutput("b2b_first", frameLen(8, 1));
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        checkOutput("b2b_second", frameLen(8, 1));
        checkIdle("post_b2b", 4);

        $display("[TB] parity frames 0x07 even/odd");
        applyStimulus(0, 8'h07, 8, 1, 1'b0, 1'b0);
        checkOutput("par_even", frameLen(8, 1));
        checkIdle("post_par_even", 2);
        sel = 3;
        checkIdle("pre_par_odd", 1);
        applyStimulus(3, 8'h07, 8, 1, 1'b1, 1'b0);
        checkOutput("par_odd", frameLen(8, 1));
        checkIdle("post_par_odd", 2);

        $display("[TB] two stop bits 0x3C");
        sel = 1;
        checkIdle("pre_stop2", 1);
        applyStimulus(1, 8'h3C, 8, 2, 1'b0, 1'b0);
        checkOutput("stop2", frameLen(8, 2));
        checkIdle("post_stop2", 4);

        $display("[TB] reset mid-frame");
        sel = 0;
        checkIdle("pre_rst", 1);
        applyStimulus(0, 8'h96, 8, 1, 1'b0, 1'b0);
        checkOutput("pre_abort", 13);
        #1;
        rst = 1'b1;
        #1;
        checkBit("abort tx", obs_tx, 1'b1);
        checkBit("abort ready", obs_ready, 1'b1);
        checkBit("abort busy", obs_busy, 1'b0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkIdle("post_rst", 3);
        applyStimulus(0, 8'h55, 8, 1, 1'b0, 1'b0);
        checkOutput("after_rst_55", frameLen(8, 1));
        checkIdle("post_55", 2);

        $display("[TB] 5 data bits 0x1F with pulse while busy");
        sel = 2;
        checkIdle("pre_5bit", 1);
        applyStimulus(2, 8'h1F, 5, 1, 1'b0, 1'b0);
        checkOutput("5bit_head", 10);
        in_data[2]  = 8'h00;
        in_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[2] = 1'b0;
        checkOutput("5bit_tail", frameLen(5, 1) - 10);
        checkIdle("post_5bit", 8);

        checkBit("scoreboard drained", sb.size() == 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit engine with an internal baud divider, configurable data bits and stop bits, optional parity, and a valid/ready input handshake. It sits between a byte-producing client (command FIFO, debug port) and the serial pin. It accepts back-to-back frames with no idle gap on the line.

## Interface
- CLK_DIV, 16: clk cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only when UART_TX_PARITY_EN is defined.
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  client offers in_data.
- in_ready  output  1  engine can accept a word this cycle.
- in_data  input  DATA_BITS  word to send, LSB first.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line (state != IDLE).

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Accept occurs on a rising edge with in_valid && in_ready. At that edge:
  - latch in_data into the shift register;
  - compute the parity bit;
  - drive tx <= 0;
  - enter START;
  - clear the divider and bit counters.
- in_ready is asserted in two cases only:
  - in IDLE;
  - in the final clk cycle of the final stop bit.
- An accept in that final stop-bit cycle goes directly to START, so the line shows no idle gap between frames.
- In every other state, in_valid and in_data are ignored. A client may deassert in_valid without a handshake.
- The divider counts 0..CLK_DIV-1. Each state advances when the divider reaches CLK_DIV-1.
- START advances to DATA and drives tx = shift[0].
- DATA shifts right at each bit boundary and counts DATA_BITS bits. After the last data bit it goes to PARITY if the macro is defined, otherwise to STOP.
- PARITY drives the stored parity bit for one bit time, then goes to STOP.
- STOP drives tx = 1 for STOP_BITS bit times, then:
  - goes to START if an accept occurs at that edge;
  - otherwise goes to IDLE.
- tx is a register with no combinational path from the inputs.
- Reset values: tx = 1, in_ready = 1, busy = 0, state = IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately: tx goes high asynchronously and the in-flight word is discarded. Frames are not resumed after reset.

## Timing
- Accept at edge k: the start bit occupies the cycles after edges k .. k+CLK_DIV-1.
- Frame length N = CLK_DIV × (1 + DATA_BITS + P + STOP_BITS) cycles, where P = 1 with parity and 0 without.
- Sustained throughput: one word per N cycles. in_ready is high for exactly 1 cycle per frame under continuous load.
- busy rises at the accepting edge. It falls only at the edge that ends the last stop bit with no new accept.
- Counter widths:
  - divider: $clog2(CLK_DIV);
  - bit counter: $clog2(DATA_BITS+1).
- No arithmetic wider than the counters.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state and parity register exist. Parity bit = ^in_data ^ PARITY_ODD, computed at accept. The frame carries one parity bit between the data bits and the stop bits.
  - Undefined: no PARITY state and no parity logic. PARITY_ODD is ignored and the frame has no parity bit.

## Structure
- Shared package uart_pkg holds:
  - the state enum typedef uart_tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - the parameter legality constants (min/max DATA_BITS, min CLK_DIV).
- Sub-module uart_baud_tick:
  - parametrised by CLK_DIV;
  - inputs: clk, rst, clear;
  - output: one-cycle tick at the end of each bit period.
  - The receiver reuses it.
- Top level: FSM, shift register, bit counter, parity register.

## Test plan
- CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, no parity; send 0xA5 -> tx holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles. Total 40 cycles, then idle high, busy low.
- Same configuration, in_valid held high with 0x00 then 0xFF:
  - second start bit begins exactly 40 cycles after the first accept;
  - in_ready is high only at cycle 39;
  - tx shows no high gap between the frames beyond the stop bit.
- Macro defined, PARITY_ODD=0, send 0x07 -> parity bit 1 after the data bits. With PARITY_ODD=1 -> parity bit 0. Frame is 44 cycles at CLK_DIV=4.
- STOP_BITS=2, CLK_DIV=4, send 0x3C -> stop phase of 8 high cycles. in_ready reasserts only in the last (44th) cycle.
- Assert rst at cycle 13 of a frame -> tx = 1 and in_ready = 1 immediately, busy = 0. After release, the next send of 0x55 produces a clean full frame.
- DATA_BITS=5, send 0x1F with in_valid pulsed while busy -> only one frame: 0,1,1,1,1,1,1. The pulse during busy is ignored, with no second frame.
